// File: rtl/cdu_bcd_pkg.sv
// cdu_bcd_pkg: shared types, constants and helpers for the cdu_bcd_counter slice.
//   BCD_DIGIT_W  : width of one BCD digit (4 bits)
//   BCD_MAX      : largest legal BCD digit value (9)
//   bcd_digit_t  : one BCD digit
//   is_bcd()     : digit holds a legal decimal value (0..9)
//   is_nine()    : digit is at its terminal value (9)
package cdu_bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    function automatic logic is_bcd(input bcd_digit_t digit);
        return (digit <= BCD_MAX);
    endfunction

    function automatic logic is_nine(input bcd_digit_t digit);
        return (digit == BCD_MAX);
    endfunction

endpackage

// File: rtl/cdu_bcd_digit.sv
// cdu_bcd_digit: one decade stage of the BCD counter.
//   CLK      : rising-edge clock
//   CD       : synchronous active-low clear
//   LD       : synchronous parallel load (beats increment)
//   ld_digit : nibble loaded when LD=1 (loaded unchanged even if > 9)
//   inc      : increment this digit on the next edge (carry in from lower digits)
//   digit    : current digit value
//   nine     : digit == 9
//   valid    : digit <= 9
module cdu_bcd_digit
    import cdu_bcd_pkg::*;
(
    input  logic       CLK,
    input  logic       CD,
    input  logic       LD,
    input  bcd_digit_t ld_digit,
    input  logic       inc,
    output bcd_digit_t digit,
    output logic       nine,
    output logic       valid
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    // inc is only raised by the top when every digit is legal, so the
    // increment path never sees a value above 9.
    always_comb begin
        digit_d = digit_q;
        if (LD) begin
            digit_d = ld_digit;
        end else if (inc) begin
            digit_d = is_nine(digit_q) ? bcd_digit_t'(0) : digit_q + bcd_digit_t'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!CD) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign nine  = is_nine(digit_q);
    assign valid = is_bcd(digit_q);

endmodule

// File: rtl/cdu_bcd_counter.sv
// cdu_bcd_counter: DIGITS-digit BCD up counter with load, enable and cascade carry.
//   CLK : rising-edge clock
//   CD  : synchronous active-low clear (beats load)
//   D   : parallel load data, digit k at D[4k+3:4k]
//   LD  : synchronous parallel load (independent of EN/CAI)
//   EN  : count enable
//   CAI : cascade carry-in (tie 1 on the least significant stage)
//   Q   : current count, digit k at Q[4k+3:4k]
//   CAO : combinational carry-out = CAI & EN & (Q is all nines)
//   ERR : illegal-BCD load flag, present only when CDU_BCD_ERR_EN is defined
// A count containing any digit above 9 freezes until a load or clear.
module cdu_bcd_counter
    import cdu_bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  CLK,
    input  logic                  CD,
    input  logic [4*DIGITS-1:0]   D,
    input  logic                  LD,
    input  logic                  EN,
    input  logic                  CAI,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  CAO
`ifdef CDU_BCD_ERR_EN
    ,
    output logic                  ERR
`endif
);

    logic [DIGITS-1:0] nine;
    logic [DIGITS-1:0] valid;
    logic [DIGITS-1:0] inc;
    logic              all_valid;
    logic              all_nine;
    logic              count_cond;

    always_comb begin
        all_valid  = &valid;
        all_nine   = &nine;
        count_cond = CAI && EN && all_valid;
        // Ripple: digit k advances when every lower digit is at 9.
        inc[0] = count_cond;
        for (int k = 1; k < DIGITS; k++) begin
            inc[k] = inc[k-1] && nine[k-1];
        end
    end

    // all_nine already implies every digit is legal.
    assign CAO = CAI && EN && all_nine;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        cdu_bcd_digit u_digit (
            .CLK      (CLK),
            .CD       (CD),
            .LD       (LD),
            .ld_digit (D[4*k +: 4]),
            .inc      (inc[k]),
            .digit    (Q[4*k +: 4]),
            .nine     (nine[k]),
            .valid    (valid[k])
        );
    end

`ifdef CDU_BCD_ERR_EN
    logic d_illegal;
    logic err_q;
    logic err_d;

    always_comb begin
        d_illegal = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (!is_bcd(D[4*k +: 4])) begin
                d_illegal = 1'b1;
            end
        end
        err_d = err_q;
        if (LD) begin
            err_d = d_illegal;
        end
    end

    always_ff @(posedge CLK) begin
        if (!CD) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`endif

endmodule

// File: tb/tb_cdu_bcd_counter.sv
module tb_cdu_bcd_counter;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic          cd, ld, en, cai;
    logic [W-1:0]  d;
    logic [W-1:0]  q;
    logic          cao;
`ifdef CDU_BCD_ERR_EN
    logic          err;
`endif

    cdu_bcd_counter #(.DIGITS(DIGITS)) u_dut (
        .CLK (clk),
        .CD  (cd),
        .D   (d),
        .LD  (ld),
        .EN  (en),
        .CAI (cai),
        .Q   (q),
        .CAO (cao)
`ifdef CDU_BCD_ERR_EN
        ,
        .ERR (err)
`endif
    );

    // ---------------- cascade pair ----------------
    logic          c_cd, c_ld, c_en;
    logic [2*W-1:0] c_d;
    logic [W-1:0]  c_q_lo, c_q_hi;
    logic          c_cao_lo, c_cao_hi;
`ifdef CDU_BCD_ERR_EN
    logic          c_err_lo, c_err_hi;
`endif

    cdu_bcd_counter #(.DIGITS(DIGITS)) u_lo (
        .CLK (clk),
        .CD  (c_cd),
        .D   (c_d[W-1:0]),
        .LD  (c_ld),
        .EN  (c_en),
        .CAI (1'b1),
        .Q   (c_q_lo),
        .CAO (c_cao_lo)
`ifdef CDU_BCD_ERR_EN
        ,
        .ERR (c_err_lo)
`endif
    );

    cdu_bcd_counter #(.DIGITS(DIGITS)) u_hi (
        .CLK (clk),
        .CD  (c_cd),
        .D   (c_d[2*W-1:W]),
        .LD  (c_ld),
        .EN  (c_en),
        .CAI (c_cao_lo),
        .Q   (c_q_hi),
        .CAO (c_cao_hi)
`ifdef CDU_BCD_ERR_EN
        ,
        .ERR (c_err_hi)
`endif
    );

    // ---------------- reference model ----------------
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] m_q;
    logic         m_err;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic legal(input logic [W-1:0] v);
        for (int k = 0; k < DIGITS; k++) begin
            if (int'(v[4*k +: 4]) > 9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int to_int(input logic [W-1:0] v);
        int r = 0;
        for (int k = 0; k < DIGITS; k++) r = r + int'(v[4*k +: 4]) * pow10(k);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int n);
        logic [W-1:0] r = '0;
        for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((n / pow10(k)) % 10);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the main DUT: apply inputs, check CAO before the edge
    // against the pre-edge model, advance model, check Q (and ERR) after.
    task automatic step(input string tag, input logic s_cd, input logic s_ld,
                        input logic [W-1:0] s_d, input logic s_en, input logic s_cai);
        logic exp_cao;
        cd = s_cd; ld = s_ld; d = s_d; en = s_en; cai = s_cai;
        #1;
        exp_cao = s_cai && s_en && legal(m_q) && (to_int(m_q) == pow10(DIGITS) - 1);
        check({tag, ".cao"}, 32'(cao), 32'(exp_cao));
        if (!s_cd) begin
            m_q = '0; m_err = 1'b0;
        end else if (s_ld) begin
            m_q = s_d; m_err = !legal(s_d);
        end else if (s_en && s_cai && legal(m_q)) begin
            m_q = to_bcd((to_int(m_q) + 1) % pow10(DIGITS));
        end
        @(posedge clk);
        #1;
        check({tag, ".q"}, 32'(q), 32'(m_q));
`ifdef CDU_BCD_ERR_EN
        check({tag, ".err"}, 32'(err), 32'(m_err));
`endif
    endtask

    task automatic c_step(input logic s_ld, input logic [2*W-1:0] s_d, input logic s_en);
        c_cd = 1'b1; c_ld = s_ld; c_d = s_d; c_en = s_en;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] rd;
        cd = 1'b0; ld = 1'b0; d = '0; en = 1'b0; cai = 1'b0;
        c_cd = 1'b0; c_ld = 1'b0; c_d = '0; c_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        m_q = '0; m_err = 1'b0;
        check("reset.q", 32'(q), 32'h00);
        check("reset.cao", 32'(cao), 32'h0);
        check("reset.cascade", 32'({c_q_hi, c_q_lo}), 32'h0000);

        // reset beats load
        step("load57", 1'b1, 1'b1, 8'h57, 1'b0, 1'b0);
        step("rst_vs_ld", 1'b0, 1'b1, 8'h33, 1'b1, 1'b1);
        check("rst_vs_ld.const", 32'(q), 32'h00);

        // count ripple 08 -> 09 -> 10 -> 11
        step("load08", 1'b1, 1'b1, 8'h08, 1'b0, 1'b0);
        step("cnt09", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        step("cnt10", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        step("cnt11", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        check("ripple.const", 32'(q), 32'h11);

        // terminal count
        step("load98", 1'b1, 1'b1, 8'h98, 1'b0, 1'b0);
        step("cnt99", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        check("term99.const", 32'(q), 32'h99);
        step("hold99", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        step("wrap00", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        check("wrap.const", 32'(q), 32'h00);
        // CAO reflects pre-edge Q during a load
        step("load98b", 1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
        step("ld_at99", 1'b1, 1'b1, 8'h12, 1'b1, 1'b1);

        // illegal load freezes the count
        step("loadA5", 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("frozenA5", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        check("frozen.const", 32'(q), 32'hA5);
        step("load12", 1'b1, 1'b1, 8'h12, 1'b0, 1'b0);
        step("loadF9", 1'b1, 1'b1, 8'hF9, 1'b0, 1'b0);
        step("frozenF9", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);

        // hold and load independence
        step("load42", 1'b1, 1'b1, 8'h42, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step("hold_en0", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step("hold_cai0", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("hold.const", 32'(q), 32'h42);
        step("ld_en0", 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        check("ld_en0.const", 32'(q), 32'h77);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       rd = W'($urandom);
                1:       rd = to_bcd(pow10(DIGITS) - 1 - int'($urandom_range(0, 3)));
                default: rd = to_bcd(int'($urandom_range(0, pow10(DIGITS) - 1)));
            endcase
            step("rand", ($urandom_range(0, 24) != 0), ($urandom_range(0, 5) == 0),
                 rd, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end

        // cascade: lower CAO drives upper CAI
        c_step(1'b1, 16'h0099, 1'b0);
        check("casc.ld0099", 32'({c_q_hi, c_q_lo}), 32'h0099);
        c_en = 1'b1;
        #1;
        check("casc.cao_hi_0099", 32'(c_cao_hi), 32'h0);
        c_step(1'b0, 16'h0000, 1'b1);
        check("casc.0100", 32'({c_q_hi, c_q_lo}), 32'h0100);
        c_step(1'b1, 16'h9999, 1'b0);
        c_en = 1'b1;
        #1;
        check("casc.cao_lo_9999", 32'(c_cao_lo), 32'h1);
        check("casc.cao_hi_9999", 32'(c_cao_hi), 32'h1);
        c_step(1'b0, 16'h0000, 1'b1);
        check("casc.0000", 32'({c_q_hi, c_q_lo}), 32'h0000);
        check("casc.cao_hi_0000", 32'(c_cao_hi), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
